// File: rtl/fusion_pkg.sv
// Shared types for the tile-merge board engine: move direction and FSM state.
package fusion_pkg;

  typedef enum logic [1:0] {
    IZQ = 2'd0,
    DER = 2'd1,
    ARR = 2'd2,
    ABA = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/fusion_tablero_if.sv
// Move request / result bundle between a board client (master) and the merge engine (slave).
interface fusion_tablero_if #(
  parameter int N = 4,
  parameter int W = 12
);
  import fusion_pkg::*;

  logic                              start;
  dir_t                              dir;
  logic [N-1:0][N-1:0][W-1:0]        tablero_in;
  logic [N-1:0][N-1:0][W-1:0]        tablero_out;
  logic                              ocupado;
  logic                              listo;
  logic                              movido;
  logic                              gano;
  logic [W+$clog2(N*N)-1:0]          puntos;

  modport master (
    output start, dir, tablero_in,
    input  tablero_out, ocupado, listo, movido, gano, puntos
  );

  modport slave (
    input  start, dir, tablero_in,
    output tablero_out, ocupado, listo, movido, gano, puntos
  );

endinterface

// File: rtl/fusion_linea.sv
// Combinational merge of one board line toward element 0: compact, pairwise merge, compact.
module fusion_linea #(
  parameter int N = 4,
  parameter int W = 12
) (
  input  logic [N-1:0][W-1:0]    linea_in,
  input  logic [W-1:0]           meta,
  output logic [N-1:0][W-1:0]    linea_out,
  output logic [W+$clog2(N)-1:0] puntos,
  output logic                   cambio,
  output logic                   meta_hit
);

  localparam int LW = W + $clog2(N);

  // A pair may only merge when the sum still fits in a tile.
  function automatic logic suma_cabe(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return ~s[W];
  endfunction

  // Order-preserving compaction of non-zero tiles toward element 0 (bubble of empties).
  function automatic logic [N-1:0][W-1:0] compactar(input logic [N-1:0][W-1:0] v);
    logic [N-1:0][W-1:0] r;
    logic [W-1:0]        t;
    r = v;
    for (int p = 0; p < N; p++) begin
      for (int i = 0; i < N - 1; i++) begin
        if (r[i] == '0) begin
          t      = r[i];
          r[i]   = r[i+1];
          r[i+1] = t;
        end
      end
    end
    return r;
  endfunction

  logic [N-1:0][W-1:0] comp;
  logic [N-1:0][W-1:0] fund;

  // Merge scan from element 0; a merged slot's partner is zeroed so no tile merges twice.
  always_comb begin
    comp     = compactar(linea_in);
    fund     = comp;
    puntos   = '0;
    meta_hit = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (fund[i] != '0 && fund[i] == fund[i+1] && suma_cabe(fund[i], fund[i+1])) begin
        fund[i]   = fund[i] + fund[i+1];
        fund[i+1] = '0;
        puntos    = puntos + LW'(fund[i]);
        if (fund[i] == meta) meta_hit = 1'b1;
      end
    end
    linea_out = compactar(fund);
    cambio    = (linea_out != linea_in);
  end

endmodule

// File: rtl/fusion_tablero.sv
// Board move engine: latches a board and direction, then merges one line per cycle
// through a single shared fusion_linea, accumulating score, change and goal flags.
module fusion_tablero
  import fusion_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 12,
  parameter int META = 2048
) (
  input logic             clk,
  input logic             rst,
  fusion_tablero_if.slave bus
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = W + $clog2(N*N);
  localparam int LW = W + $clog2(N);
  localparam logic [W-1:0] META_V = W'(META);

  estado_t                    estado;
  dir_t                       dir_q;
  logic [FW-1:0]              fila;
  logic [N-1:0][N-1:0][W-1:0] tab;
  logic                       ocupado_q;
  logic                       listo_q;
  logic                       movido_q;
  logic                       gano_q;
  logic [PW-1:0]              puntos_q;

  logic [N-1:0][W-1:0]        lin_in;
  logic [N-1:0][W-1:0]        lin_out;
  logic [LW-1:0]              lin_pts;
  logic                       lin_cambio;
  logic                       lin_meta;

  // Pick the current line out of the working board, element 0 at the destination edge.
  always_comb begin
    lin_in = '0;
    for (int k = 0; k < N; k++) begin
      case (dir_q)
        IZQ:     lin_in[k] = tab[fila][k];
        DER:     lin_in[k] = tab[fila][N-1-k];
        ARR:     lin_in[k] = tab[k][fila];
        default: lin_in[k] = tab[N-1-k][fila];
      endcase
    end
  end

  fusion_linea #(.N(N), .W(W)) u_linea (
    .linea_in  (lin_in),
    .meta      (META_V),
    .linea_out (lin_out),
    .puntos    (lin_pts),
    .cambio    (lin_cambio),
    .meta_hit  (lin_meta)
  );

  // Move sequencer; listo is registered on the FIN exit so it flags the first settled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= IDLE;
      dir_q     <= IZQ;
      fila      <= '0;
      tab       <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      movido_q  <= 1'b0;
      gano_q    <= 1'b0;
      puntos_q  <= '0;
    end else begin
      listo_q <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.start) begin
            tab       <= bus.tablero_in;
            dir_q     <= bus.dir;
            fila      <= '0;
            movido_q  <= 1'b0;
            gano_q    <= 1'b0;
            puntos_q  <= '0;
            ocupado_q <= 1'b1;
            estado    <= PROC;
          end
        end
        PROC: begin
          for (int k = 0; k < N; k++) begin
            case (dir_q)
              IZQ:     tab[fila][k]     <= lin_out[k];
              DER:     tab[fila][N-1-k] <= lin_out[k];
              ARR:     tab[k][fila]     <= lin_out[k];
              default: tab[N-1-k][fila] <= lin_out[k];
            endcase
          end
          puntos_q <= puntos_q + PW'(lin_pts);
          movido_q <= movido_q | lin_cambio;
          gano_q   <= gano_q | lin_meta;
          if (fila == FW'(N - 1)) begin
            estado <= FIN;
          end else begin
            fila <= fila + FW'(1);
          end
        end
        FIN: begin
          listo_q   <= 1'b1;
          ocupado_q <= 1'b0;
          estado    <= IDLE;
        end
        default: begin
          estado    <= IDLE;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tablero_out = tab;
  assign bus.ocupado     = ocupado_q;
  assign bus.listo       = listo_q;
  assign bus.movido      = movido_q;
  assign bus.gano        = gano_q;
  assign bus.puntos      = puntos_q;

endmodule

// File: tb/tb_fusion_tablero.sv
// Directed bench for fusion_tablero with hand-computed boards, scores and timing.
module tb_fusion_tablero;
  import fusion_pkg::*;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int PW = W + $clog2(N*N);
  localparam int LAT = N + 1;

  typedef logic [N-1:0][N-1:0][W-1:0] tab_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fusion_tablero_if #(.N(N), .W(W)) bus();

  fusion_tablero #(.N(N), .W(W), .META(2048)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one move; lat = edges from the accepting edge to listo, -1 on timeout.
  task automatic run_move(input tab_t b, input dir_t d, output int lat, output logic ocu);
    tab_t junk;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dir        = d;
    bus.tablero_in = b;
    @(posedge clk);
    #1 ocu = bus.ocupado;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        junk[r][c] = 12'd2;
    bus.tablero_in = junk;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.listo) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", bus.ocupado); end
    checks++; if (bus.listo !== 1'b0) begin errors++; $display("FAIL reset_listo: got %b expected 0", bus.listo); end
    checks++; if ({bus.movido, bus.gano} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.movido, bus.gano}); end
    checks++; if (bus.puntos !== PW'(0)) begin errors++; $display("FAIL reset_puntos: got %0d expected 0", bus.puntos); end
    checks++; if (bus.tablero_out !== tab_t'(0)) begin errors++; $display("FAIL reset_board: got %h expected 0", bus.tablero_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_izq_basic();
    tab_t b, e;
    int lat; logic ocu;
    b = '0; e = '0;
    for (int c = 0; c < N; c++) b[0][c] = 12'd2;
    e[0][0] = 12'd4; e[0][1] = 12'd4;
    run_move(b, IZQ, lat, ocu);
    checks++; if (ocu !== 1'b1) begin errors++; $display("FAIL izq_ocupado: got %b expected 1", ocu); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL izq_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL izq_board: got %h expected %h", bus.tablero_out, e); end
    checks++; if (bus.puntos !== PW'(8)) begin errors++; $display("FAIL izq_puntos: got %0d expected 8", bus.puntos); end
    checks++; if (bus.movido !== 1'b1) begin errors++; $display("FAIL izq_movido: got %b expected 1", bus.movido); end
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("FAIL izq_ocupado_end: got %b expected 0", bus.ocupado); end
    @(posedge clk); #1;
    checks++; if (bus.listo !== 1'b0) begin errors++; $display("FAIL izq_listo_pulse: got %b expected 0", bus.listo); end
  endtask

  task automatic test_merge_rows();
    tab_t b, e;
    int lat; logic ocu;
    b = '0; e = '0;
    b[0][0] = 12'd16; b[0][2] = 12'd16; b[0][3] = 12'd32;
    b[1][0] = 12'd2;  b[1][1] = 12'd2;  b[1][2] = 12'd4;
    b[2][1] = 12'd2;  b[2][3] = 12'd2;
    b[3][0] = 12'd4;  b[3][3] = 12'd4;
    e[0][0] = 12'd32; e[0][1] = 12'd32;
    e[1][0] = 12'd4;  e[1][1] = 12'd4;
    e[2][0] = 12'd4;
    e[3][0] = 12'd8;
    run_move(b, IZQ, lat, ocu);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rows_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL rows_board: got %h expected %h", bus.tablero_out, e); end
    checks++; if (bus.puntos !== PW'(48)) begin errors++; $display("FAIL rows_puntos: got %0d expected 48", bus.puntos); end
    checks++; if (bus.gano !== 1'b0) begin errors++; $display("FAIL rows_gano: got %b expected 0", bus.gano); end
  endtask

  task automatic test_aba();
    tab_t b, e;
    int lat; logic ocu;
    b = '0; e = '0;
    b[0][0] = 12'd2; b[2][0] = 12'd2; b[3][0] = 12'd4;
    e[2][0] = 12'd4; e[3][0] = 12'd4;
    run_move(b, ABA, lat, ocu);
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL aba_board: got %h expected %h", bus.tablero_out, e); end
    checks++; if (bus.puntos !== PW'(4)) begin errors++; $display("FAIL aba_puntos: got %0d expected 4", bus.puntos); end
    checks++; if (bus.movido !== 1'b1) begin errors++; $display("FAIL aba_movido: got %b expected 1", bus.movido); end
  endtask

  task automatic test_arr();
    tab_t b, e;
    int lat; logic ocu;
    b = '0; e = '0;
    b[1][1] = 12'd8; b[2][1] = 12'd8; b[3][1] = 12'd16;
    e[0][1] = 12'd16; e[1][1] = 12'd16;
    run_move(b, ARR, lat, ocu);
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL arr_board: got %h expected %h", bus.tablero_out, e); end
    checks++; if (bus.puntos !== PW'(16)) begin errors++; $display("FAIL arr_puntos: got %0d expected 16", bus.puntos); end
  endtask

  task automatic test_der_no_move();
    tab_t b;
    int lat; logic ocu;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[r][c] = (((r + c) % 2) == 0) ? 12'd2 : 12'd4;
    run_move(b, DER, lat, ocu);
    checks++; if (bus.tablero_out !== b) begin errors++; $display("FAIL der_board: got %h expected %h", bus.tablero_out, b); end
    checks++; if (bus.movido !== 1'b0) begin errors++; $display("FAIL der_movido: got %b expected 0", bus.movido); end
    checks++; if (bus.puntos !== PW'(0)) begin errors++; $display("FAIL der_puntos: got %0d expected 0", bus.puntos); end
  endtask

  task automatic test_gano_hold();
    tab_t b, e;
    int lat; logic ocu;
    b = '0; e = '0;
    b[0][0] = 12'd1024; b[0][1] = 12'd1024;
    e[0][0] = 12'd2048;
    run_move(b, IZQ, lat, ocu);
    checks++; if (bus.gano !== 1'b1) begin errors++; $display("FAIL gano_flag: got %b expected 1", bus.gano); end
    checks++; if (bus.puntos !== PW'(2048)) begin errors++; $display("FAIL gano_puntos: got %0d expected 2048", bus.puntos); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL hold_board: got %h expected %h", bus.tablero_out, e); end
    checks++; if ({bus.gano, bus.movido} !== 2'b11) begin errors++; $display("FAIL hold_flags: got %b expected 11", {bus.gano, bus.movido}); end
    checks++; if (bus.puntos !== PW'(2048)) begin errors++; $display("FAIL hold_puntos: got %0d expected 2048", bus.puntos); end
  endtask

  task automatic test_overflow();
    tab_t b;
    int lat; logic ocu;
    b = '0;
    b[0][0] = 12'd2048; b[0][1] = 12'd2048;
    run_move(b, IZQ, lat, ocu);
    checks++; if (bus.tablero_out !== b) begin errors++; $display("FAIL ovf_board: got %h expected %h", bus.tablero_out, b); end
    checks++; if ({bus.gano, bus.movido} !== 2'b00) begin errors++; $display("FAIL ovf_flags: got %b expected 00", {bus.gano, bus.movido}); end
    checks++; if (bus.puntos !== PW'(0)) begin errors++; $display("FAIL ovf_puntos: got %0d expected 0", bus.puntos); end
  endtask

  task automatic test_reset_mid_move();
    tab_t b, e;
    int lat; logic ocu;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[r][c] = 12'd2;
    @(negedge clk);
    bus.start = 1'b1; bus.dir = IZQ; bus.tablero_in = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("FAIL midrst_ocupado: got %b expected 0", bus.ocupado); end
    checks++; if (bus.tablero_out !== tab_t'(0)) begin errors++; $display("FAIL midrst_board: got %h expected 0", bus.tablero_out); end
    checks++; if (bus.puntos !== PW'(0)) begin errors++; $display("FAIL midrst_puntos: got %0d expected 0", bus.puntos); end
    @(negedge clk);
    rst = 1'b0;
    b = '0; e = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd2;
    e[0][0] = 12'd4;
    run_move(b, IZQ, lat, ocu);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL midrst_board2: got %h expected %h", bus.tablero_out, e); end
  endtask

  task automatic test_start_held();
    tab_t b, e;
    int   cnt;
    logic listo5, ocu5, ocu0, ocu6;
    b = '0; e = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd2;
    e[0][0] = 12'd4;
    @(negedge clk);
    bus.start = 1'b1; bus.dir = IZQ; bus.tablero_in = b;
    @(posedge clk);
    #1 ocu0 = bus.ocupado;
    cnt = 0; listo5 = 1'b0; ocu5 = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      if (bus.listo) cnt++;
      if (i == LAT) begin listo5 = bus.listo; ocu5 = bus.ocupado; end
    end
    @(posedge clk);
    #1 ocu6 = bus.ocupado;
    checks++; if (ocu0 !== 1'b1) begin errors++; $display("FAIL held_accept: got %b expected 1", ocu0); end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL held_listo_count: got %0d expected 1", cnt); end
    checks++; if ({listo5, ocu5} !== 2'b10) begin errors++; $display("FAIL held_listo_idle: got %b expected 10", {listo5, ocu5}); end
    checks++; if (ocu6 !== 1'b1) begin errors++; $display("FAIL held_reaccept: got %b expected 1", ocu6); end
    @(negedge clk);
    bus.start = 1'b0;
    cnt = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.listo) begin cnt = i; break; end
    end
    checks++; if (cnt < 0) begin errors++; $display("FAIL held_second_done: got timeout expected listo"); end
    checks++; if (bus.tablero_out !== e) begin errors++; $display("FAIL held_board: got %h expected %h", bus.tablero_out, e); end
    checks++; if (bus.puntos !== PW'(4)) begin errors++; $display("FAIL held_puntos: got %0d expected 4", bus.puntos); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.dir        = IZQ;
    bus.tablero_in = '0;
    test_reset();
    test_izq_basic();
    test_merge_rows();
    test_aba();
    test_arr();
    test_der_no_move();
    test_gano_hold();
    test_overflow();
    test_reset_mid_move();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fusion_tablero.md
FUSION_TABLERO -- requirements
Module: fusion_tablero

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning board side length (N ≥ 2, even).
REQ-002 The block SHALL have parameter W, default 12, meaning tile value width (the tile value is stored directly, 0 = empty).
REQ-003 The block SHALL have parameter META, default 2048, meaning the tile value that raises gano.
REQ-004 Port: clk  in  1  the single clock; all logic is rising-edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  request to process one move.
REQ-007 Port: dir  in  2  move direction, of type dir_t.
REQ-008 Port: tablero_in  in  [N][N] x W  board, indexed [row][col], sampled only on an accepted start.
REQ-009 Port: tablero_out  out  [N][N] x W  result board.
REQ-010 Port: ocupado  out  1  move in progress.
REQ-011 Port: listo  out  1  one-cycle completion pulse.
REQ-012 Port: movido  out  1  result differs from the input board.
REQ-013 Port: gano  out  1  some merge produced META.
REQ-014 Port: puntos  out  W+$clog2(N*N)  sum of all merged tile values for this move.

Function
REQ-015 The FSM SHALL have states IDLE, PROC and FIN.
REQ-016 In IDLE with start=1, the block SHALL latch tablero_in and dir into the working board, clear movido/gano/puntos, set line index to 0 and go to PROC.
REQ-017 In PROC, each cycle SHALL process exactly one line (index 0..N-1) and write it back; after line N-1 the FSM SHALL go to FIN.
REQ-018 FIN SHALL last one cycle with listo=1 and then return to IDLE.
REQ-019 Latency SHALL be: start sampled at edge k; listo high during the cycle after edge k+N+1; total N+2 cycles start-to-listo.
REQ-020 ocupado SHALL be 1 in PROC and FIN and 0 in IDLE.
REQ-021 start SHALL be ignored while ocupado=1, and tablero_in changes during a move SHALL have no effect.
REQ-022 Line extraction, with element 0 as the destination end, SHALL be: IZQ = row r, col 0..N-1; DER = row r, col N-1..0; ARR = col r, row 0..N-1; ABA = col r, row N-1..0.
REQ-023 Per line, the block SHALL compact non-zero tiles toward element 0, then merge equal adjacent pairs scanning from element 0 so that each tile merges at most once, then compact again.
REQ-024 Merge examples: [2,2,2,2]→[4,4,0,0]; [2,2,4,0]→[4,4,0,0]; [0,2,0,2]→[4,0,0,0]; [4,0,0,4]→[8,0,0,0].
REQ-025 Overflow rule: a pair whose sum exceeds 2^W-1 SHALL NOT merge (both tiles remain, only compacted).
REQ-026 puntos SHALL accumulate every merged sum; movido SHALL be set if any processed line changed; gano SHALL be set if any merged sum equals META.
REQ-027 tablero_out, movido, gano and puntos SHALL hold their values from FIN until the next accepted start.
REQ-028 tablero_out SHALL show the working board at all times; it is guaranteed final only when listo=1 or the block is in IDLE after a move.

Reset
REQ-029 rst=1 SHALL force IDLE, clear the working board (tablero_out all 0) and set ocupado, listo, movido, gano and puntos to 0, including mid-move; rst SHALL take priority over start.

Structure
REQ-030 Package fusion_pkg SHALL hold dir_t (IZQ=2'd0, DER=2'd1, ARR=2'd2, ABA=2'd3) and the FSM state typedef.
REQ-031 Sub-module fusion_linea (combinational, parameters N and W) SHALL take one N-element line and return the merged line, the line score, a changed flag and a meta-hit flag; it SHALL be instantiated once and time-multiplexed over the lines.

Verification
REQ-032 With N=4, W=12, row0=[2,2,2,2] and dir=IZQ: row0=[4,4,0,0], puntos=8, movido=1, listo 6 cycles after start.
REQ-033 With column0 top-to-bottom=[2,0,2,4] and dir=ABA: column0=[0,0,4,4] top-to-bottom, puntos=4.
REQ-034 With a board having no legal move and dir=DER: board unchanged, movido=0, puntos=0.
REQ-035 With row=[1024,1024,0,0] and dir=IZQ: gano=1; with row=[2048,2048,0,0] and W=12, no merge occurs (overflow rule), and the result is [2048,2048,0,0].
REQ-036 With rst asserted during the 3rd PROC cycle: next cycle ocupado=0 and tablero_out=0; a new start then completes normally.
REQ-037 With start held high through a move: only one move executes per IDLE entry, listo pulses once, and the next start is accepted in IDLE.
